// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame constants,
// FSM state encoding and a counter-width helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        TX_START_BIT = 3'd1,
        TX_DATA_BITS = 3'd2,
        TX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4
    } uart_state_e;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the transmitter. Pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    // Full is judged before any same-cycle pop, so a push into a full buffer
    // is refused even while the head is leaving.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone
    // define which entries are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge i_Clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8N1 frames, LSB first, each bit CLKS_PER_BIT clocks.
// Line, active and done outputs are registered copies of the FSM's decode.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_TX_Done
);

    localparam int                CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e          state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [DATA_BITS-1:0] shift_reg, shift_d;
    logic                 serial_d, active_d, done_d;
    logic                 serial_q, active_q, done_q;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .push      (i_TX_DV),
        .push_data (i_TX_Byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_TX_Ready  = !fifo_full;
    assign o_TX_Serial = serial_q;
    assign o_TX_Active = active_q;
    assign o_TX_Done   = done_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift_reg <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            shift_reg <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // Outputs decode the current state and are registered, so the line trails
    // the state by one clock; that lag produces the two-edge start latency.
    always_comb begin
        // NOTE: every signal driven here gets a default first; otherwise a path
        // that skips an assignment would infer a latch.
        state_d  = state;
        cnt_d    = cnt;
        idx_d    = idx;
        shift_d  = shift_reg;
        fifo_pop = 1'b0;
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = TX_START_BIT;
                end
            end

            TX_START_BIT: begin
                serial_d = 1'b0;
                active_d = 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = TX_DATA_BITS;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            TX_DATA_BITS: begin
                serial_d = shift_reg[idx];
                active_d = 1'b1;
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = TX_STOP_BIT;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            TX_STOP_BIT: begin
                serial_d = 1'b1;
                active_d = 1'b1;
                if (cnt == CNT_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = CLEANUP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            CLEANUP: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end

            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4: exact
// waveform vectors, back-to-back framing, full-buffer and reset corners, loopback.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;

    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    bit         mon_en = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line levels per bit period, earliest bit leftmost
    } vec_t;

    vec_t vecs[6];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_TX_DV     (tx_dv),
        .i_TX_Byte   (tx_byte),
        .o_TX_Ready  (tx_ready),
        .o_TX_Serial (tx_serial),
        .o_TX_Active (tx_active),
        .o_TX_Done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference line for bytes queued back to back, t counted in clocks from
    // the negedge after the first accepted push: {serial, active, done}.
    function automatic logic [2:0] stream_model(input int t, input logic [7:0] b0,
                                                input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bs[3];
        int u, f, r, k;
        logic s;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        if (t < 2) return 3'b100;
        u = t - 2;
        f = u / (10 * CPB + 2);
        r = u % (10 * CPB + 2);
        if (f > 2 || r >= 10 * CPB) return 3'b100;
        k = r / CPB;
        if (k == 0)      s = 1'b0;
        else if (k == 9) s = 1'b1;
        else             s = bs[f][k-1];
        return {s, 1'b1, (r == 10 * CPB - 1)};
    endfunction

    task automatic send(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        tx_dv = 1'b1;
        tx_byte = b;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = tx_ready;
            @(posedge clk);
            #1;
        end
        tx_dv = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
        check("rx_count", rx_q.size(), n);
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    // Line receiver: samples each bit in the middle of its period.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx_serial === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                check("rx_start_bit", tx_serial, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_serial;
                end
                repeat (CPB) @(negedge clk);
                check("rx_stop_bit", tx_serial, 1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int bad;
        logic [2:0] m;
        logic [7:0] b;

        vecs[0] = '{8'hA5, 10'b0_10100101_1};
        vecs[1] = '{8'h00, 10'b0_00000000_1};
        vecs[2] = '{8'hFF, 10'b0_11111111_1};
        vecs[3] = '{8'h01, 10'b0_10000000_1};
        vecs[4] = '{8'h80, 10'b0_00000001_1};
        vecs[5] = '{8'hC5, 10'b0_10100011_1};

        // Reset state, with a strobe held during reset that must be ignored.
        #1 rst_n = 1'b0;
        tx_dv = 1'b1;
        tx_byte = 8'hAA;
        repeat (3) @(negedge clk);
        check("rst_serial", tx_serial, 1);
        check("rst_active", tx_active, 0);
        check("rst_done", tx_done, 0);
        check("rst_ready", tx_ready, 1);
        @(posedge clk);
        #1 tx_dv = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_active !== 1'b0) bad++;
        end
        check("no_push_in_reset", bad, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Exact single-frame waveforms from idle.
        foreach (vecs[v]) begin
            rx_q.delete();
            d0 = done_cnt;
            tx_dv = 1'b1;
            tx_byte = vecs[v].data;
            @(posedge clk);
            #1 tx_dv = 1'b0;
            for (int t = 0; t < 46; t++) begin
                logic es, ea, ed;
                if (t < 2)         begin es = 1'b1; ea = 1'b0; ed = 1'b0; end
                else if (t < 42)   begin es = vecs[v].line[9 - (t - 2) / CPB]; ea = 1'b1; ed = (t == 41); end
                else               begin es = 1'b1; ea = 1'b0; ed = 1'b0; end
                @(negedge clk);
                check("vec_serial", tx_serial, es);
                check("vec_active", tx_active, ea);
                check("vec_done", tx_done, ed);
            end
            wait_rx(1, 100);
            check("vec_rx_byte", rx_q[0], vecs[v].data);
            check("vec_done_pulses", done_cnt - d0, 1);
            @(posedge clk);
            #1;
        end

        // Three bytes on consecutive edges: frames in order, 2 idle cycles apart.
        rx_q.delete();
        d0 = done_cnt;
        tx_dv = 1'b1;
        tx_byte = 8'h00;
        @(posedge clk);
        #1;
        fork
            begin
                tx_byte = 8'hFF;
                @(posedge clk);
                #1 tx_byte = 8'h55;
                @(posedge clk);
                #1 tx_dv = 1'b0;
            end
            begin
                for (int t = 0; t < 136; t++) begin
                    m = stream_model(t, 8'h00, 8'hFF, 8'h55);
                    @(negedge clk);
                    check("b2b_serial", tx_serial, m[2]);
                    check("b2b_active", tx_active, m[1]);
                    check("b2b_done", tx_done, m[0]);
                end
            end
        join
        wait_rx(3, 200);
        check("b2b_rx0", rx_q[0], 8'h00);
        check("b2b_rx1", rx_q[1], 8'hFF);
        check("b2b_rx2", rx_q[2], 8'h55);
        check("b2b_done_pulses", done_cnt - d0, 3);
        @(posedge clk);
        #1;

        // Fill the buffer while busy, strobe into a full buffer, then hold a
        // strobe across the pop edge.
        rx_q.delete();
        d0 = done_cnt;
        send(8'h11);
        repeat (6) begin @(posedge clk); #1; end
        send(8'h21);
        send(8'h32);
        send(8'h43);
        send(8'h54);
        @(negedge clk);
        check("ready_low_when_full", tx_ready, 0);
        @(posedge clk);
        #1 tx_dv = 1'b1;
        tx_byte = 8'h65;
        @(negedge clk);
        check("ready_low_on_fifth", tx_ready, 0);
        @(posedge clk);
        #1 tx_dv = 1'b0;
        send(8'h76);
        wait_rx(6, 400);
        exp_q = '{8'h11, 8'h21, 8'h32, 8'h43, 8'h54, 8'h76};
        for (int i = 0; i < 6; i++) check("full_rx_order", rx_q[i], exp_q[i]);
        check("full_done_pulses", done_cnt - d0, 6);
        @(posedge clk);
        #1;

        // Reset during data bit 3 of 0x3C with two more bytes queued.
        mon_en = 1'b0;
        d0 = done_cnt;
        tx_dv = 1'b1;
        tx_byte = 8'h3C;
        @(posedge clk);
        #1 tx_byte = 8'hA1;
        @(posedge clk);
        #1 tx_byte = 8'hB2;
        @(posedge clk);
        #1 tx_dv = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset_bit3", tx_serial, 1);
        check("pre_reset_active", tx_active, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_serial", tx_serial, 1);
        check("abort_active", tx_active, 0);
        check("abort_done", tx_done, 0);
        check("abort_ready", tx_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        check("post_reset_quiet", bad, 0);
        check("abort_no_done", done_cnt - d0, 0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Randomised loopback of 256 bytes with random gaps.
        rx_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send(b);
        end
        wait_rx(256, 256 * 50);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < rx_q.size()) check("loop_byte", rx_q[i], exp_q[i]);
            else bad++;
        end
        check("loop_missing", bad, 0);
        check("loop_done_pulses", done_cnt - d0, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, clocks per UART bit (i_Clk frequency / baud); legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, input byte buffer entries; power of two, >= 2.
REQ-003 i_Clk  input  1  single clock for all logic.
REQ-004 i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-005 i_TX_DV  input  1  byte-valid strobe from host.
REQ-006 i_TX_Byte  input  8  byte to transmit, sampled when i_TX_DV and o_TX_Ready are both high.
REQ-007 o_TX_Ready  output  1  high when the buffer can accept a byte.
REQ-008 o_TX_Serial  output  1  serial line; idle high.
REQ-009 o_TX_Active  output  1  high from the first start-bit cycle through the last stop-bit cycle.
REQ-010 o_TX_Done  output  1  one-cycle pulse at completion of each frame.

Function
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; each bit held exactly CLKS_PER_BIT cycles.
REQ-012 Byte accepted on a rising edge where i_TX_DV=1 and o_TX_Ready=1; i_TX_DV while o_TX_Ready=0 SHALL be ignored, with no buffer state change.
REQ-013 o_TX_Ready SHALL equal NOT full; a push to a full buffer SHALL be refused even if a pop occurs in the same cycle.
REQ-014 Buffer is FIFO-ordered; read/write pointers carry one extra wrap bit; full = indices equal and wrap bits differ; empty = pointers equal.
REQ-015 States: IDLE, TX_START_BIT, TX_DATA_BITS, TX_STOP_BIT, CLEANUP; any unused encoding SHALL go to IDLE.
REQ-016 IDLE: o_TX_Serial=1, counters cleared; if buffer non-empty, pop head into shift register, go TX_START_BIT.
REQ-017 TX_START_BIT: o_TX_Serial=0 for CLKS_PER_BIT cycles, then TX_DATA_BITS with bit index 0.
REQ-018 TX_DATA_BITS: o_TX_Serial=shift[index] for CLKS_PER_BIT cycles per bit; index 0..7; after index 7 go TX_STOP_BIT.
REQ-019 TX_STOP_BIT: o_TX_Serial=1 for CLKS_PER_BIT cycles; on last cycle assert o_TX_Done for that one cycle, go CLEANUP.
REQ-020 CLEANUP: one cycle, o_TX_Serial=1, o_TX_Done=0, then IDLE.
REQ-021 Latency: byte pushed into an empty buffer with FSM in IDLE at edge N SHALL produce o_TX_Serial=0 after edge N+2.
REQ-022 Back-to-back frames SHALL be separated by exactly 2 idle-high cycles (CLEANUP + IDLE).
REQ-023 Bit counter width ceil(log2(CLKS_PER_BIT)) bits, counts 0..CLKS_PER_BIT-1, never wraps past terminal value.
REQ-024 o_TX_Serial, o_TX_Active, o_TX_Done SHALL be registered outputs (glitch-free line).
REQ-025 Pushes SHALL be accepted in every state, including mid-frame.

Reset
REQ-026 While i_Rst_L=0: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, FSM=IDLE, buffer empty, all counters 0.
REQ-027 Reset asserted mid-frame SHALL abort immediately; line returns high asynchronously; buffered bytes discarded.
REQ-028 No byte SHALL be accepted on an edge where i_Rst_L=0.

Structure
REQ-029 State encodings and frame constants (data bits = 8) SHALL live in shared package uart_pkg, common with the receiver.
REQ-030 Buffer SHALL be sub-module uart_tx_fifo (parameter DEPTH, push/pop/full/empty); FSM and shift register in uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Push 0xA5 from idle -> line 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4; o_TX_Done one pulse on last stop cycle.
REQ-032 Push 0x00,0xFF,0x55 consecutively -> three frames in order, 2 high cycles between frames, 3 o_TX_Done pulses.
REQ-033 Push 5 bytes with no pops possible (FSM busy) -> o_TX_Ready low after 4th accepted byte; 5th strobe ignored; 4 frames sent.
REQ-034 Buffer full, i_TX_DV high on the cycle FSM pops -> push refused that cycle, accepted next cycle; no byte lost or duplicated.
REQ-035 Assert i_Rst_L=0 during data bit 3 of 0x3C with 2 bytes queued -> o_TX_Serial=1 immediately, no o_TX_Done, after release line stays high, o_TX_Ready=1.
REQ-036 Loopback o_TX_Serial into receiver, random 256 bytes -> received stream matches transmitted stream exactly.
